// File: rtl/reg_bank_funsel_if.sv
// Bus bundle for reg_bank_funsel: shared op/data inputs, two read
// ports and the per-register wrap flags.
//   master: drives FunSel/RegSel/I/OutASel/OutBSel, observes OutA/OutB/Wrap
//   slave : the register bank itself
interface reg_bank_funsel_if #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 4
);
    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [2:0]          FunSel;
    logic [NUM_REGS-1:0] RegSel;
    logic [WIDTH-1:0]    I;
    logic [SEL_W-1:0]    OutASel;
    logic [SEL_W-1:0]    OutBSel;
    logic [WIDTH-1:0]    OutA;
    logic [WIDTH-1:0]    OutB;
    logic [NUM_REGS-1:0] Wrap;

    modport master (
        output FunSel,
        output RegSel,
        output I,
        output OutASel,
        output OutBSel,
        input  OutA,
        input  OutB,
        input  Wrap
    );

    modport slave (
        input  FunSel,
        input  RegSel,
        input  I,
        input  OutASel,
        input  OutBSel,
        output OutA,
        output OutB,
        output Wrap
    );
endinterface

// File: rtl/reg_bank_funsel.sv
// Bank of NUM_REGS WIDTH-bit registers sharing one FunSel op and input bus,
// with per-register enables, two combinational read ports and sticky wrap flags.
// Ports: Clock, ResetN (async, active-low), bus (reg_bank_funsel_if.slave):
//   FunSel/RegSel/I select and feed the update, OutASel/OutBSel pick the
//   registers shown on OutA/OutB, Wrap holds one sticky flag per register.
// Build option: define SATURATE_EN to make inc/dec clamp at the boundaries
//   instead of wrapping (the Wrap flag is still raised at the boundary).
module reg_bank_funsel #(
    parameter int               WIDTH       = 16,
    parameter int               NUM_REGS    = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clock,
    input  logic             ResetN,
    reg_bank_funsel_if.slave bus
);

    localparam int H     = WIDTH / 2;
    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TAB   = 1 << SEL_W;

    logic [WIDTH-1:0]    reg_q [NUM_REGS];
    logic [WIDTH-1:0]    reg_d [NUM_REGS];
    logic [NUM_REGS-1:0] wrap_q;
    logic [NUM_REGS-1:0] wrap_d;

    // One-hot view of FunSel
    logic op_dec;
    logic op_inc;
    logic op_load;
    logic op_clr;
    logic op_loz;
    logic op_lo;
    logic op_hi;
    logic op_sext;

    assign op_dec  = (bus.FunSel == 3'b000);
    assign op_inc  = (bus.FunSel == 3'b001);
    assign op_load = (bus.FunSel == 3'b010);
    assign op_clr  = (bus.FunSel == 3'b011);
    assign op_loz  = (bus.FunSel == 3'b100);
    assign op_lo   = (bus.FunSel == 3'b101);
    assign op_hi   = (bus.FunSel == 3'b110);
    assign op_sext = (bus.FunSel == 3'b111);

    // Input low half and its sign-extended form are shared by all registers
    logic [H-1:0]     in_lo;
    logic [WIDTH-1:0] in_sext;

    assign in_lo   = bus.I[H-1:0];
    assign in_sext = {{(WIDTH-H){in_lo[H-1]}}, in_lo};

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            reg_d[k]  = reg_q[k];
            wrap_d[k] = wrap_q[k];
            if (bus.RegSel[k]) begin
                unique case (1'b1)
                    op_dec: begin
                        reg_d[k] = reg_q[k] - 1'b1;
                        if (reg_q[k] == '0) begin
                            wrap_d[k] = 1'b1;
`ifdef SATURATE_EN
                            reg_d[k] = '0;
`endif
                        end
                    end
                    op_inc: begin
                        reg_d[k] = reg_q[k] + 1'b1;
                        if (reg_q[k] == '1) begin
                            wrap_d[k] = 1'b1;
`ifdef SATURATE_EN
                            reg_d[k] = '1;
`endif
                        end
                    end
                    op_load: begin
                        reg_d[k]  = bus.I;
                        wrap_d[k] = 1'b0;
                    end
                    op_clr: begin
                        reg_d[k]  = '0;
                        wrap_d[k] = 1'b0;
                    end
                    op_loz: begin
                        reg_d[k]  = {{(WIDTH-H){1'b0}}, in_lo};
                        wrap_d[k] = 1'b0;
                    end
                    op_lo: begin
                        reg_d[k]  = {reg_q[k][WIDTH-1:H], in_lo};
                        wrap_d[k] = 1'b0;
                    end
                    op_hi: begin
                        reg_d[k]  = {in_lo, reg_q[k][H-1:0]};
                        wrap_d[k] = 1'b0;
                    end
                    op_sext: begin
                        reg_d[k]  = in_sext;
                        wrap_d[k] = 1'b0;
                    end
                    default: begin
                        reg_d[k]  = reg_q[k];
                        wrap_d[k] = wrap_q[k];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                reg_q[k] <= RESET_VALUE;
            end
            wrap_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                reg_q[k] <= reg_d[k];
            end
            wrap_q <= wrap_d;
        end
    end

    // Read table padded to the full select range; unused slots read zero
    // so an out-of-range index on a non-power-of-2 bank is well defined.
    logic [WIDTH-1:0] rd_tab [TAB];

    for (genvar g = 0; g < TAB; g++) begin : g_rd
        if (g < NUM_REGS) begin : g_reg
            assign rd_tab[g] = reg_q[g];
        end else begin : g_pad
            assign rd_tab[g] = '0;
        end
    end

    assign bus.OutA = rd_tab[bus.OutASel];
    assign bus.OutB = rd_tab[bus.OutBSel];
    assign bus.Wrap = wrap_q;

endmodule

// File: tb/tb_reg_bank_funsel.sv
// Self-checking bench for reg_bank_funsel: directed scenarios, random ops
// against an arithmetic reference model, and a 3-register bank instance.
module tb_reg_bank_funsel;

`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic Clock;
    logic ResetN;

    int n_assert = 0;
    int n_fail   = 0;

    reg_bank_funsel_if #(.WIDTH(16), .NUM_REGS(4)) bus ();
    reg_bank_funsel_if #(.WIDTH(16), .NUM_REGS(3)) b3 ();

    reg_bank_funsel #(.WIDTH(16), .NUM_REGS(4)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus)
    );

    reg_bank_funsel #(.WIDTH(16), .NUM_REGS(3)) dut3 (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (b3)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference model: plain integers
    int unsigned m [4];
    bit          w [4];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m[k] = 0;
            w[k] = 1'b0;
        end
    endtask

    task automatic model_op(input logic [2:0] fs, input logic [3:0] rs,
                            input int unsigned iv);
        int unsigned lo;
        lo = iv % 256;
        for (int k = 0; k < 4; k++) begin
            if (rs[k]) begin
                case (fs)
                    3'd0: begin
                        if (m[k] == 0) begin
                            w[k] = 1'b1;
                            m[k] = SAT ? 0 : 65535;
                        end else m[k] = m[k] - 1;
                    end
                    3'd1: begin
                        if (m[k] == 65535) begin
                            w[k] = 1'b1;
                            m[k] = SAT ? 65535 : 0;
                        end else m[k] = m[k] + 1;
                    end
                    3'd2: begin m[k] = iv; w[k] = 1'b0; end
                    3'd3: begin m[k] = 0; w[k] = 1'b0; end
                    3'd4: begin m[k] = lo; w[k] = 1'b0; end
                    3'd5: begin
                        m[k] = (m[k] / 256) * 256 + lo;
                        w[k] = 1'b0;
                    end
                    3'd6: begin
                        m[k] = lo * 256 + (m[k] % 256);
                        w[k] = 1'b0;
                    end
                    default: begin
                        m[k] = (lo >= 128) ? lo + 65280 : lo;
                        w[k] = 1'b0;
                    end
                endcase
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input int k,
                           input logic [15:0] exp);
        bus.OutASel = 2'(k);
        bus.OutBSel = 2'(k);
        #1;
        chk({tag, "_A"}, {16'h0, bus.OutA}, {16'h0, exp});
        chk({tag, "_B"}, {16'h0, bus.OutB}, {16'h0, exp});
    endtask

    task automatic chk_model(input string tag);
        logic [3:0] wv;
        for (int k = 0; k < 4; k++) begin
            bus.OutASel = 2'(k);
            bus.OutBSel = 2'(3 - k);
            #1;
            chk({tag, "_A"}, {16'h0, bus.OutA}, m[k]);
            chk({tag, "_B"}, {16'h0, bus.OutB}, m[3-k]);
            wv[k] = w[k];
        end
        chk({tag, "_wrap"}, {28'h0, bus.Wrap}, {28'h0, wv});
    endtask

    task automatic apply(input logic [2:0] fs, input logic [3:0] rs,
                         input logic [15:0] iv);
        bus.FunSel = fs;
        bus.RegSel = rs;
        bus.I      = iv;
        @(posedge Clock);
        model_op(fs, rs, iv);
        #1;
        bus.RegSel = 4'b0000;
    endtask

    initial begin
        ResetN      = 1'b0;
        bus.FunSel  = 3'b000;
        bus.RegSel  = '0;
        bus.I       = '0;
        bus.OutASel = '0;
        bus.OutBSel = '0;
        b3.FunSel   = 3'b000;
        b3.RegSel   = '0;
        b3.I        = '0;
        b3.OutASel  = '0;
        b3.OutBSel  = '0;
        model_reset();

        #2;
        chk_model("reset");
        @(posedge Clock);
        #1;
        ResetN = 1'b1;

        // Half-word loads on R0
        apply(3'b010, 4'b0001, 16'h1234);
        chk_reg("load", 0, 16'h1234);
        apply(3'b110, 4'b0001, 16'h00AB);
        chk_reg("hiload", 0, 16'hAB34);
        apply(3'b101, 4'b0001, 16'h00CD);
        chk_reg("loload", 0, 16'hABCD);
        apply(3'b100, 4'b0001, 16'h7780);
        chk_reg("loloadz", 0, 16'h0080);
        chk_model("t2");

        // Sign extension on R1
        apply(3'b111, 4'b0010, 16'h0080);
        chk_reg("sext_neg", 1, 16'hFF80);
        apply(3'b111, 4'b0010, 16'h007F);
        chk_reg("sext_pos", 1, 16'h007F);

        // Wrap flag on R2
        apply(3'b010, 4'b0100, 16'hFFFF);
        apply(3'b001, 4'b0100, 16'h0000);
        chk_reg("inc_top", 2, SAT ? 16'hFFFF : 16'h0000);
        chk("wrap_set", {31'h0, bus.Wrap[2]}, 32'h1);
        apply(3'b001, 4'b0100, 16'h0000);
        chk("wrap_sticky", {31'h0, bus.Wrap[2]}, 32'h1);
        apply(3'b010, 4'b0100, 16'h0005);
        chk("wrap_clr", {31'h0, bus.Wrap[2]}, 32'h0);
        apply(3'b011, 4'b0100, 16'h0000);
        apply(3'b000, 4'b0100, 16'h0000);
        chk_reg("dec_zero", 2, SAT ? 16'h0000 : 16'hFFFF);
        chk("wrap_dec", {31'h0, bus.Wrap[2]}, 32'h1);
        chk_model("t4");

        // Broadcast ops and read-before-write
        apply(3'b011, 4'b1111, 16'h0000);
        for (int n = 0; n < 3; n++) apply(3'b001, 4'b1111, 16'h0000);
        chk_model("bcast");
        chk_reg("same_sel", 1, 16'h0003);
        bus.FunSel  = 3'b010;
        bus.RegSel  = 4'b0001;
        bus.I       = 16'hBEEF;
        bus.OutASel = 2'd0;
        bus.OutBSel = 2'd0;
        #1;
        chk("old_val", {16'h0, bus.OutA}, 32'h0003);
        @(posedge Clock);
        model_op(3'b010, 4'b0001, 32'hBEEF);
        #1;
        bus.RegSel = 4'b0000;
        chk("new_val", {16'h0, bus.OutA}, 32'hBEEF);

        // Async reset mid-cycle, with a wrap flag pending
        apply(3'b011, 4'b0100, 16'h0000);
        apply(3'b000, 4'b0100, 16'h0000);
        chk("pre_rst_wrap", {31'h0, bus.Wrap[2]}, 32'h1);
        #1;
        ResetN = 1'b0;
        model_reset();
        #1;
        chk_model("async_rst");
        @(posedge Clock);
        #1;
        ResetN = 1'b1;
        chk_model("post_rst");

        // Random ops against the model
        for (int n = 0; n < 300; n++) begin
            logic [2:0]  fs;
            logic [3:0]  rs;
            logic [15:0] iv;
            fs = 3'($urandom_range(0, 7));
            rs = 4'($urandom);
            iv = 16'($urandom);
            // Bias some registers toward the wrap boundaries
            if ($urandom_range(0, 9) == 0) iv = 16'hFFFF;
            apply(fs, rs, iv);
            chk_model("rand");
        end

        // Three-register bank: pad read and idle RegSel
        b3.FunSel = 3'b010;
        b3.RegSel = 3'b111;
        b3.I      = 16'h4242;
        @(posedge Clock);
        #1;
        b3.RegSel  = 3'b000;
        b3.OutASel = 2'd3;
        b3.OutBSel = 2'd2;
        #1;
        chk("n3_pad", {16'h0, b3.OutA}, 32'h0000);
        chk("n3_r2", {16'h0, b3.OutB}, 32'h4242);
        b3.FunSel = 3'b010;
        b3.I      = 16'h1111;
        @(posedge Clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            b3.OutASel = 2'(k);
            #1;
            chk("n3_hold", {16'h0, b3.OutA}, 32'h4242);
        end
        chk("n3_wrap", {29'h0, b3.Wrap}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
